// File: rtl/codificador_constante.sv
`default_nettype none
// ============================================================================
// codificador_constante
//   Splits a 16-bit constant into one or two (controle, constante) extender
//   beats whose OR after extension rebuilds the original value.
//   Rev 1.0 - initial release
// ============================================================================
module codificador_constante #(
  parameter int          DEST_W    = 3,
  parameter int unsigned ENABLE_ZX = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       in_valor,
  input  logic [DEST_W-1:0] in_dest,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out_controle,
  output logic [10:0]       out_constante,
  output logic [DEST_W-1:0] out_dest,
  output logic              out_last,
  output logic [15:0]       pares_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ALTO   = 2'd1,
    ULTIMO = 2'd2
  } estado_t;

  localparam logic [1:0] CTRL_SEXT = 2'b00;
  localparam logic [1:0] CTRL_ZEXT = 2'b01;
  localparam logic [1:0] CTRL_HIGH = 2'b10;

  estado_t             state_q, state_d;
  logic [1:0]          controle_q, controle_d;
  logic [10:0]         constante_q, constante_d;
  logic [DEST_W-1:0]   dest_q, dest_d;
  logic                last_q, last_d;
  logic [7:0]          baixo_q, baixo_d;
  logic [15:0]         pares_q, pares_d;

  logic                rule_sext, rule_zext, rule_high;
  logic [1:0]          enc_controle;
  logic [10:0]         enc_constante;
  logic                enc_par;
  logic                aceita;

  // Encoding of the incoming value; first matching form wins.
  assign rule_sext = (&in_valor[15:10]) | ~(|in_valor[15:10]);
  assign rule_zext = (ENABLE_ZX != 0) && (in_valor[15:11] == 5'd0);
  assign rule_high = (in_valor[7:0] == 8'd0);

  always_comb begin
    enc_controle  = CTRL_HIGH;
    enc_constante = {3'b000, in_valor[15:8]};
    enc_par       = 1'b1;
    if (rule_sext) begin
      enc_controle  = CTRL_SEXT;
      enc_constante = in_valor[10:0];
      enc_par       = 1'b0;
    end else if (rule_zext) begin
      enc_controle  = CTRL_ZEXT;
      enc_constante = in_valor[10:0];
      enc_par       = 1'b0;
    end else if (rule_high) begin
      enc_par       = 1'b0;
    end
  end

  always_comb begin
    state_d     = state_q;
    controle_d  = controle_q;
    constante_d = constante_q;
    dest_d      = dest_q;
    last_d      = last_q;
    baixo_d     = baixo_q;
    pares_d     = pares_q;
    in_ready    = 1'b0;

    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      ALTO: begin
        if (out_ready) begin
          controle_d  = CTRL_ZEXT;
          constante_d = {3'b000, baixo_q};
          last_d      = 1'b1;
          state_d     = ULTIMO;
        end
      end
      ULTIMO: begin
        // Ready follows the consumer so a new request can replace the last beat.
        in_ready = out_ready;
        if (out_ready && !in_valid) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    aceita = in_valid && in_ready;
    if (aceita) begin
      controle_d  = enc_controle;
      constante_d = enc_constante;
      dest_d      = in_dest;
      last_d      = ~enc_par;
      baixo_d     = in_valor[7:0];
      state_d     = enc_par ? ALTO : ULTIMO;
      if (enc_par && (pares_q != 16'hFFFF)) begin
        pares_d = pares_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      controle_q  <= 2'b00;
      constante_q <= 11'd0;
      dest_q      <= '0;
      last_q      <= 1'b0;
      baixo_q     <= 8'd0;
      pares_q     <= 16'd0;
    end else begin
      state_q     <= state_d;
      controle_q  <= controle_d;
      constante_q <= constante_d;
      dest_q      <= dest_d;
      last_q      <= last_d;
      baixo_q     <= baixo_d;
      pares_q     <= pares_d;
    end
  end

  assign out_valid     = (state_q != IDLE);
  assign out_controle  = controle_q;
  assign out_constante = constante_q;
  assign out_dest      = dest_q;
  assign out_last      = last_q;
  assign pares_count   = pares_q;

endmodule
`default_nettype wire
